// File: rtl/group_xor_reducer.sv
// group_xor_reducer
//   Splits each WIDTH-bit input beat into WIDTH/GROUP contiguous groups and
//   reduces every group to a single parity bit. In per-beat mode each
//   accepted beat produces one result. In frame mode the group parities are
//   XOR-accumulated across beats and emitted once, on the beat marked last.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears state, accumulator and outputs
//   in_valid   source offers a beat
//   in_ready   block can take a beat this cycle (decoded from state only)
//   in_data    beat data, WIDTH bits
//   in_last    final beat of a frame (frame mode only)
//   mode       0 = result per beat, 1 = accumulate until in_last
//   out_valid  result is held on out_data/out_count
//   out_ready  consumer takes the result
//   out_data   reduced parities, WIDTH/GROUP bits, MSB from the MSB group
//   out_count  number of beats folded into out_data, saturating
module group_xor_reducer #(
  parameter int WIDTH = 4,
  parameter int GROUP = 2,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH/GROUP-1:0]   out_data,
  output logic [CNTW-1:0]          out_count
);

  localparam int NG = WIDTH / GROUP;

  if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_bad_params
    $error("group_xor_reducer: WIDTH must be a non-zero multiple of GROUP");
  end

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  // Parity of each GROUP-bit slice; group i lands on result bit i.
  function automatic logic [NG-1:0] reduce(input logic [WIDTH-1:0] d);
    logic [NG-1:0] r;
    r = '0;
    for (int i = 0; i < NG; i++) begin
      r[i] = ^d[i*GROUP +: GROUP];
    end
    return r;
  endfunction

  // Beat counter clamps at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    if (c == {CNTW{1'b1}}) return c;
    return c + CNTW'(1);
  endfunction

  state_t          state, state_n;
  logic [NG-1:0]   acc;
  logic [CNTW-1:0] cnt;
  logic            fmode;

  logic            accept;
  logic            eff_mode;
  logic            finish;
  logic [NG-1:0]   nxt;
  logic [CNTW-1:0] cnt_n;

  // Beat decode: frame mode comes from the live input only on a frame's
  // first beat; later beats use the value latched then.
  always_comb begin
    accept   = in_valid && (state == ACC);
    eff_mode = (cnt == '0) ? mode : fmode;
    finish   = (eff_mode == 1'b0) || in_last;
    nxt      = acc ^ reduce(in_data);
    cnt_n    = sat_inc(cnt);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ACC: if (accept && finish) state_n = OUT;
      OUT: if (out_ready)        state_n = ACC;
      default:                   state_n = ACC;
    endcase
  end

  // Output decode: handshake flags depend on state alone.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == OUT);
  end

  // Accumulator, counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      fmode     <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (cnt == '0) fmode <= mode;
            if (finish) begin
              out_data  <= nxt;
              out_count <= cnt_n;
            end else begin
              acc <= nxt;
              cnt <= cnt_n;
            end
          end
        end
        OUT: begin
          // Result registers hold until the consumer takes them.
          if (out_ready) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_group_xor_reducer.sv
module tb_group_xor_reducer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut0: default WIDTH=4, GROUP=2, CNTW=8
  logic       in_valid0, in_ready0, in_last0, mode0, out_valid0, out_ready0;
  logic [3:0] in_data0;
  logic [1:0] out_data0;
  logic [7:0] out_count0;

  // dut1: WIDTH=12, GROUP=3
  logic        in_valid1, in_ready1, in_last1, mode1, out_valid1, out_ready1;
  logic [11:0] in_data1;
  logic [3:0]  out_data1;
  logic [7:0]  out_count1;

  // dut2: WIDTH=4, GROUP=1
  logic       in_valid2, in_ready2, in_last2, mode2, out_valid2, out_ready2;
  logic [3:0] in_data2;
  logic [3:0] out_data2;
  logic [7:0] out_count2;

  // dut3: WIDTH=4, GROUP=2, CNTW=2
  logic       in_valid3, in_ready3, in_last3, mode3, out_valid3, out_ready3;
  logic [3:0] in_data3;
  logic [1:0] out_data3;
  logic [1:0] out_count3;

  group_xor_reducer #(.WIDTH(4), .GROUP(2), .CNTW(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_last(in_last0), .mode(mode0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_count(out_count0));

  group_xor_reducer #(.WIDTH(12), .GROUP(3), .CNTW(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_last(in_last1), .mode(mode1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_count(out_count1));

  group_xor_reducer #(.WIDTH(4), .GROUP(1), .CNTW(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_last(in_last2), .mode(mode2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_count(out_count2));

  group_xor_reducer #(.WIDTH(4), .GROUP(2), .CNTW(2)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_last(in_last3), .mode(mode3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .out_count(out_count3));

  // Hand-computed {d3^d2, d1^d0} for d = 0..15
  logic [1:0] sweep_exp [16] = '{2'b00, 2'b01, 2'b01, 2'b00,
                                 2'b10, 2'b11, 2'b11, 2'b10,
                                 2'b10, 2'b11, 2'b11, 2'b10,
                                 2'b00, 2'b01, 2'b01, 2'b00};

  // Offer one beat to dut0 and return just after the accepting edge.
  task automatic beat0(input logic [3:0] d, input logic last, input logic md);
    int n;
    n = 0;
    in_data0  = d;
    in_last0  = last;
    mode0     = md;
    in_valid0 = 1'b1;
    while (!in_ready0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL beat0_timeout: in_ready stayed %b, required 1", in_ready0);
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_last0  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid0);
    end
    checks++;
    if (out_data0 !== 2'b00) begin
      errors++; $display("FAIL reset_out_data: got %b, required 00", out_data0);
    end
    checks++;
    if (out_count0 !== 8'd0) begin
      errors++; $display("FAIL reset_out_count: got %0d, required 0", out_count0);
    end
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready0);
    end
  endtask

  task automatic test_mode0_sweep();
    int results;
    results = 0;
    out_ready0 = 1'b1;
    for (int d = 0; d < 16; d++) begin
      beat0(4'(d), 1'b0, 1'b0);
      checks++;
      if (out_valid0 !== 1'b1) begin
        errors++; $display("FAIL sweep_valid d=%0d: got %b, required 1", d, out_valid0);
      end else begin
        results++;
      end
      checks++;
      if (out_data0 !== sweep_exp[d]) begin
        errors++;
        $display("FAIL sweep_data d=%0d: got %b, required %b", d, out_data0, sweep_exp[d]);
      end
      checks++;
      if (out_count0 !== 8'd1) begin
        errors++; $display("FAIL sweep_count d=%0d: got %0d, required 1", d, out_count0);
      end
    end
    checks++;
    if (results != 16) begin
      errors++; $display("FAIL sweep_results: got %0d, required 16", results);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mode1_frame();
    out_ready0 = 1'b1;
    beat0(4'b0110, 1'b0, 1'b1);
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++; $display("FAIL frame_beat1_valid: got %b, required 0", out_valid0);
    end
    // mode drops mid-frame; the latched frame mode must stay in force
    beat0(4'b1011, 1'b0, 1'b0);
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++; $display("FAIL frame_beat2_valid: got %b, required 0", out_valid0);
    end
    beat0(4'b0001, 1'b1, 1'b0);
    checks++;
    if (out_valid0 !== 1'b1) begin
      errors++; $display("FAIL frame_valid: got %b, required 1", out_valid0);
    end
    checks++;
    if (out_data0 !== 2'b00) begin
      errors++; $display("FAIL frame_data: got %b, required 00", out_data0);
    end
    checks++;
    if (out_count0 !== 8'd3) begin
      errors++; $display("FAIL frame_count: got %0d, required 3", out_count0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready0 = 1'b0;
    beat0(4'b1000, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 2'b10 || in_ready0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d: valid=%b data=%b in_ready=%b, required 1 10 0",
                 c, out_valid0, out_data0, in_ready0);
      end
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b valid=%b, required 1 0", in_ready0, out_valid0);
    end
  endtask

  task automatic test_reset_mid_frame();
    out_ready0 = 1'b1;
    beat0(4'b1100, 1'b0, 1'b1);
    beat0(4'b0011, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    beat0(4'b0100, 1'b1, 1'b1);
    checks++;
    if (out_data0 !== 2'b10 || out_count0 !== 8'd1 || out_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_frame: valid=%b data=%b count=%0d, required 1 10 1",
               out_valid0, out_data0, out_count0);
    end
    @(posedge clk); #1;
    // Reset while a result is pending drops it
    out_ready0 = 1'b0;
    beat0(4'b0101, 1'b0, 1'b0);
    checks++;
    if (out_valid0 !== 1'b1) begin
      errors++; $display("FAIL rst_pending_pre: got %b, required 1", out_valid0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || out_data0 !== 2'b00) begin
      errors++;
      $display("FAIL rst_pending_drop: valid=%b data=%b, required 0 00", out_valid0, out_data0);
    end
    out_ready0 = 1'b1;
  endtask

  task automatic test_param_w12();
    out_ready1 = 1'b1;
    in_data1   = 12'hA5C;
    mode1      = 1'b0;
    in_valid1  = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 4'b0101 || out_count1 !== 8'd1) begin
      errors++;
      $display("FAIL w12_g3: valid=%b data=%b count=%0d, required 1 0101 1",
               out_valid1, out_data1, out_count1);
    end
  endtask

  task automatic test_group1();
    out_ready2 = 1'b1;
    in_data2   = 4'b1010;
    mode2      = 1'b0;
    in_valid2  = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 4'b1010) begin
      errors++;
      $display("FAIL group1: valid=%b data=%b, required 1 1010", out_valid2, out_data2);
    end
  endtask

  task automatic test_saturation();
    out_ready3 = 1'b1;
    mode3      = 1'b1;
    in_data3   = 4'b0001;
    for (int b = 1; b <= 5; b++) begin
      in_last3  = (b == 5);
      in_valid3 = 1'b1;
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      if (b < 5) begin
        checks++;
        if (out_valid3 !== 1'b0) begin
          errors++; $display("FAIL sat_early_valid b=%0d: got %b, required 0", b, out_valid3);
        end
      end
    end
    in_last3 = 1'b0;
    checks++;
    if (out_valid3 !== 1'b1 || out_count3 !== 2'd3 || out_data3 !== 2'b01) begin
      errors++;
      $display("FAIL sat_result: valid=%b count=%0d data=%b, required 1 3 01",
               out_valid3, out_count3, out_data3);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; in_last0 = 1'b0; mode0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; in_last1 = 1'b0; mode1 = 1'b0; out_ready1 = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0; mode2 = 1'b0; out_ready2 = 1'b1;
    in_valid3 = 1'b0; in_data3 = '0; in_last3 = 1'b0; mode3 = 1'b0; out_ready3 = 1'b1;

    test_reset();
    test_mode0_sweep();
    test_mode1_frame();
    test_backpressure();
    test_reset_mid_frame();
    test_param_w12();
    test_group1();
    test_saturation();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
